im_loader: RTL and testbench

IM_LOADER -- requirements
Module: im_loader

---
 rtl/im_loader_pkg.sv | 16 +
 rtl/im_loader_asm.sv | 34 +++
 rtl/im_loader.sv | 142 ++++++++++++++
 tb/tb_im_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and word geometry.
package im_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_WRITE,
      ST_CHECK,
      ST_DONE
   } state_t;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned WORD_W         = BYTES_PER_WORD * 8;
   localparam int unsigned DEFAULT_ADDR_W = 6;

endpackage

// File: rtl/im_loader_asm.sv
// Byte-to-word assembler: little-endian shift register plus byte position counter.
module im_loader_asm
   import im_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              byte_en,
   input  logic [7:0]        in_data,
   output logic [WORD_W-1:0] word,
   output logic              word_valid
);

   logic [WORD_W-9:0] shreg_q;
   logic [1:0]        cnt_q;

   // The 4th byte is not stored; the word is presented combinationally as it transfers.
   assign word_valid = byte_en && (cnt_q == 2'(BYTES_PER_WORD - 1));
   assign word       = {in_data, shreg_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else if (clr) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else if (byte_en) begin
         shreg_q <= {in_data, shreg_q[WORD_W-9:8]};
         cnt_q   <= cnt_q + 2'd1;
      end
   end

endmodule

// File: rtl/im_loader.sv
// Streams program bytes into instruction memory while holding the CPU.
// Optional trailer checksum verification is enabled by defining IM_LOADER_CHECKSUM_EN.
module im_loader
   import im_loader_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   num_words,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [DATA_W-1:0] im_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t              state_q, state_d;
   logic [ADDR_W:0]     num_q;
   logic [ADDR_W:0]     idx_q;
   logic [ADDR_W:0]     idx_inc;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [WORD_W-1:0]   asm_word;
   logic                word_valid;
   logic                start_acc;
   logic                last_word;

   assign start_acc = start && (state_q == ST_IDLE || state_q == ST_DONE);
   assign idx_inc   = idx_q + {{ADDR_W{1'b0}}, 1'b1};
   // Index is one bit wider than the address so a full-depth load terminates without wrapping.
   assign last_word = (idx_inc == num_q);

   im_loader_asm u_asm (
      .clk        (clk),
      .rst        (rst),
      .clr        (start_acc),
      .byte_en    (in_valid && in_ready),
      .in_data    (in_data),
      .word       (asm_word),
      .word_valid (word_valid)
   );

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      im_we    = 1'b0;
      busy     = 1'b1;
      cpu_hold = 1'b1;
      done     = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            busy     = 1'b0;
            cpu_hold = 1'b0;
            done     = (state_q == ST_DONE);
            if (start)
               state_d = (num_words == '0) ? ST_DONE : ST_COLLECT;
         end
         ST_COLLECT: begin
            in_ready = 1'b1;
            if (word_valid)
               state_d = ST_WRITE;
         end
         ST_WRITE: begin
            im_we = 1'b1;
            if (!last_word)
               state_d = ST_COLLECT;
            else
`ifdef IM_LOADER_CHECKSUM_EN
               state_d = ST_CHECK;
`else
               state_d = ST_DONE;
`endif
         end
`ifdef IM_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            in_ready = 1'b1;
            if (word_valid)
               state_d = ST_DONE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         num_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (start_acc) begin
            num_q <= num_words;
            idx_q <= '0;
         end
         if (state_q == ST_COLLECT && word_valid) begin
            wdata_q <= asm_word;
            addr_q  <= idx_q[ADDR_W-1:0];
         end
         if (state_q == ST_WRITE)
            idx_q <= idx_inc;
      end
   end

   assign im_addr  = addr_q;
   assign im_wdata = wdata_q;

`ifdef IM_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] acc_q;
   logic              err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         err_q <= 1'b0;
      end else if (start_acc) begin
         acc_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q == ST_WRITE)
            acc_q <= acc_q ^ wdata_q;
         if (state_q == ST_CHECK && word_valid)
            err_q <= (asm_word != acc_q);
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: directed and randomized loads against a word-list model.
module tb_im_loader;

   localparam int ADDR_W = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W:0]   num_words;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              err;

   im_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_words (num_words),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .im_we     (im_we),
      .im_addr   (im_addr),
      .im_wdata  (im_wdata),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [31:0]       d;
   } wr_t;

   wr_t         wlog[$];
   int          hold_cycles = 0;
   int          n_assert    = 0;
   int          fails       = 0;
   logic [31:0] wbuf[64];
   bit          tog         = 1'b0;

   always @(negedge clk) begin
      if (im_we === 1'b1) wlog.push_back('{a: im_addr, d: im_wdata});
      if (cpu_hold === 1'b1) hold_cycles++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: always valid, 1: toggling valid, 2: random gaps
   task automatic send_word(input logic [31:0] w, input int nbytes, input int mode, input int wr_before);
      for (int b = 0; b < nbytes; b++) begin
         int guard = 0;
         bit sent  = 1'b0;
         while (!sent) begin
            @(negedge clk);
            in_data = w[8*b +: 8];
            case (mode)
               0:       in_valid = 1'b1;
               1:       begin in_valid = tog; tog = !tog; end
               default: in_valid = 1'($urandom_range(0, 1));
            endcase
            sent = in_valid && in_ready;
            @(posedge clk);
            guard++;
            if (guard > 400) begin
               chk("xfer_timeout", 64'd0, 64'd1);
               return;
            end
         end
         if (b == 2) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("no_early_we", 64'(wlog.size()), 64'(wr_before));
         end
      end
   endtask

   task automatic pulse_start(input int n);
      @(negedge clk);
      start     = 1'b1;
      num_words = (ADDR_W+1)'(n);
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic run_load(input int n, input int mode, input bit bad_trailer);
      int          base = wlog.size();
      int          hb   = hold_cycles;
      logic [31:0] x    = '0;
      pulse_start(n);
      if (n > 0) chk("hold_after_start", 64'(cpu_hold), 64'd1);
      for (int i = 0; i < n; i++) begin
         send_word(wbuf[i], 4, mode, base + i);
         x ^= wbuf[i];
      end
`ifdef IM_LOADER_CHECKSUM_EN
      if (n > 0) send_word(bad_trailer ? x + 32'd1 : x, 4, mode, base + n);
`endif
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c < 20 && done !== 1'b1; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("done", 64'(done), 64'd1);
      chk("busy_end", 64'(busy), 64'd0);
      chk("hold_end", 64'(cpu_hold), 64'd0);
`ifdef IM_LOADER_CHECKSUM_EN
      chk("err", 64'(err), 64'(n > 0 && bad_trailer));
`else
      chk("err", 64'(err), 64'd0);
`endif
      chk("write_count", 64'(wlog.size() - base), 64'(n));
      if (n == 0) chk("zero_no_hold", 64'(hold_cycles - hb), 64'd0);
      for (int i = 0; i < n && base + i < wlog.size(); i++) begin
         chk($sformatf("addr[%0d]", i), 64'(wlog[base+i].a), 64'(i));
         chk($sformatf("data[%0d]", i), 64'(wlog[base+i].d), 64'(wbuf[i]));
      end
   endtask

   initial begin
      int base;
      rst = 1'b1; start = 1'b0; num_words = '0; in_data = '0; in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_im_we", 64'(im_we), 64'd0);
      chk("rst_im_addr", 64'(im_addr), 64'd0);
      chk("rst_im_wdata", 64'(im_wdata), 64'd0);
      chk("rst_hold", 64'(cpu_hold), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      rst = 1'b0;

      // Reference program from the requirements
      wbuf[0] = 32'h0000_0013; wbuf[1] = 32'h0010_0093;
      run_load(2, 0, 1'b0);

      // Zero length: done on the very next cycle
      base = wlog.size();
      pulse_start(0);
      chk("zero_done_next", 64'(done), 64'd1);
      run_load(0, 0, 1'b0);
      chk("zero_no_write", 64'(wlog.size() - base), 64'd0);

      // Stalled single word
      wbuf[0] = 32'hDEAD_BEEF;
      run_load(1, 1, 1'b0);

      // Randomized loads with random valid gaps
      for (int t = 0; t < 4; t++) begin
         int n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) wbuf[i] = $urandom;
         run_load(n, 2, 1'b0);
      end

      // Reset mid-load after two bytes of word 1
      wbuf[0] = 32'hA5A5_0001; wbuf[1] = 32'h5A5A_0002;
      base = wlog.size();
      pulse_start(2);
      send_word(wbuf[0], 4, 0, base);
      send_word(wbuf[1], 2, 0, base + 1);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
      chk("mid_rst_im_we", 64'(im_we), 64'd0);
      chk("mid_rst_im_addr", 64'(im_addr), 64'd0);
      chk("mid_rst_im_wdata", 64'(im_wdata), 64'd0);
      chk("mid_rst_hold", 64'(cpu_hold), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_rst_writes", 64'(wlog.size() - base), 64'd1);
      if (wlog.size() > base) chk("mid_rst_w0", 64'(wlog[base].d), 64'(wbuf[0]));
      run_load(2, 2, 1'b0);

      // Full depth
      for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
      run_load(64, 0, 1'b0);

`ifdef IM_LOADER_CHECKSUM_EN
      wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222;
      run_load(2, 0, 1'b0);
      run_load(2, 2, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
